fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter: DATA_W, default 8, width of data and q.
REQ-002 Parameter: DEPTH, default 16, number of storage words; power of two.
REQ-003 Parameter: ADDR_W, default 4, log2(DEPTH); width of usedw.
REQ-004 Parameter: AF_LEVEL, default 12, occupancy at or above which almost_full asserts.
REQ-005 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: sclr_n  in  1  reset; synchronous and active-low.
REQ-007 Port: data  in  DATA_W  write data, sampled when a write is accepted.
REQ-008 Port: wrreq  in  1  write request.
REQ-009 Port: rdreq  in  1  read request.
REQ-010 Port: q  out  DATA_W  read data.
REQ-011 Port: empty  out  1  high when occupancy is 0.
REQ-012 Port: full  out  1  high when occupancy equals DEPTH.
REQ-013 Port: almost_full  out  1  high when occupancy >= AF_LEVEL.
REQ-014 Port: usedw  out  ADDR_W  occupancy modulo DEPTH.

Function
REQ-015 The block SHALL hold an internal occupancy count of ADDR_W+1 bits (range 0..DEPTH) and separate write and read pointers of ADDR_W bits that wrap from DEPTH-1 to 0.
REQ-016 A write SHALL be accepted on an edge iff wrreq=1 and full=0; data is stored at the write pointer, which then advances by one.
REQ-017 A read SHALL be accepted on an edge iff rdreq=1 and empty=0; the read pointer then advances by one.
REQ-018 wrreq while full SHALL be ignored (no storage, no pointer or count change); rdreq while empty SHALL be ignored, q unchanged.
REQ-019 Simultaneous accepted write and read SHALL leave the count unchanged; with count 0 only the write is accepted (count becomes 1); with count DEPTH only the read is accepted (count becomes DEPTH-1).
REQ-020 empty, full, almost_full and usedw SHALL be registered-state decodes of the count, valid in the cycle after the accepting edge; usedw SHALL read 0 when full=1.
REQ-021 Order SHALL be strictly first-in first-out; data is never corrupted by pointer wrap-around.
REQ-022 In normal mode q SHALL be a register loaded with the word at the read pointer on the edge that accepts a read (1-cycle read latency) and SHALL hold its value otherwise.

Reset
REQ-023 On an edge with sclr_n=0 the block SHALL clear count and both pointers, set q=0, empty=1, full=0, almost_full=0, usedw=0, overriding any wrreq/rdreq that cycle.
REQ-024 Reset SHALL discard all stored words; storage contents need not be cleared.
REQ-025 Reset asserted mid-operation (partially full, during a write or read burst) SHALL produce the REQ-023 state on the next edge; the first write after release is read back first.

Configuration
REQ-026 When macro FIFO_SHOWAHEAD_EN is defined, q SHALL continuously present the word at the read pointer (head word visible with zero latency while empty=0), rdreq acting as acknowledge that advances to the next word; q value while empty=1 is 0.
REQ-027 When FIFO_SHOWAHEAD_EN is not defined, q SHALL behave per REQ-022; all other requirements are identical in both builds.

Verification
REQ-028 Reset then idle: sclr_n=0 for 5 cycles -> empty=1, full=0, almost_full=0, usedw=0, q=0.
REQ-029 Write 0x56,0xAA,0xFF,0xAA in consecutive cycles -> usedw 1,2,3,4, empty drops after first write; then 4 reads -> q=0x56,0xAA,0xFF,0xAA in order, empty=1, usedw=0.
REQ-030 Write 16 words 0x00..0x0F -> almost_full rises when usedw reaches 12, full=1 and usedw=0 after 16th; 17th write 0xEE ignored; 16 reads return 0x00..0x0F, never 0xEE.
REQ-031 Read while empty -> q and flags unchanged; simultaneous wrreq+rdreq at count 5 -> count stays 5 and FIFO order preserved across pointer wrap over 40 mixed operations.
REQ-032 Write 3 words, assert sclr_n=0 for one edge with wrreq=1 -> empty=1, usedw=0; then write 0x12 and read -> q=0x12.
REQ-033 Repeat REQ-029 with FIFO_SHOWAHEAD_EN defined -> q=0x56 one cycle after first write without rdreq, advancing on each rdreq.

Source files
------------

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with occupancy flags.
// Optional build macro: FIFO_SHOWAHEAD_EN -- when defined, q presents the
// head word combinationally (zero read latency, rdreq acts as acknowledge);
// when undefined, q is a register loaded on each accepted read.
module fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clock,
  input  logic              sclr_n,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W-1:0] usedw
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              wr_acc, rd_acc;

  // Flags are pure decodes of the registered count.
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  // Count DEPTH has all low bits clear, so usedw naturally reads 0 when full.
  assign usedw       = count_q[ADDR_W-1:0];

  assign wr_acc = wrreq && !full;
  assign rd_acc = rdreq && !empty;

  // Next-state for pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clock) begin
    if (sclr_n && wr_acc) mem[wr_ptr_q] <= data;
  end

`ifdef FIFO_SHOWAHEAD_EN
  // Head word is visible directly; forced to zero while empty.
  assign q = empty ? '0 : mem[rd_ptr_q];
`else
  logic [DATA_W-1:0] q_q;

  // Output register loaded with the head word on each accepted read.
  always_ff @(posedge clock) begin
    if (!sclr_n)     q_q <= '0;
    else if (rd_acc) q_q <= mem[rd_ptr_q];
  end

  assign q = q_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Randomised and directed self-checking bench for fifo against a queue model.
module tb_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 12;

  logic          clock = 1'b0;
  logic          sclr_n;
  logic [DW-1:0] data;
  logic          wrreq, rdreq;
  logic [DW-1:0] q;
  logic          empty, full, almost_full;
  logic [AW-1:0] usedw;

  always #5 clock = ~clock;

  fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AF_LEVEL(AF)) dut (
    .clock(clock), .sclr_n(sclr_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .empty(empty), .full(full), .almost_full(almost_full), .usedw(usedw)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] model[$];
  logic [DW-1:0] mq = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph);
    int sz;
    logic [DW-1:0] exp_q;
    sz = model.size();
`ifdef FIFO_SHOWAHEAD_EN
    exp_q = (sz == 0) ? '0 : model[0];
`else
    exp_q = mq;
`endif
    chk({ph, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({ph, ".full"},  32'(full),  32'(sz == DEPTH));
    chk({ph, ".af"},    32'(almost_full), 32'(sz >= AF));
    chk({ph, ".usedw"}, 32'(usedw), 32'(sz % DEPTH));
    chk({ph, ".q"},     32'(q),     32'(exp_q));
  endtask

  // One clock edge: drive, advance the model from the pre-edge occupancy, check.
  task automatic step(input string ph, input logic w, input logic r,
                      input logic [DW-1:0] d, input logic rst_n);
    int sz;
    logic [DW-1:0] head;
    wrreq  = w;
    rdreq  = r;
    data   = d;
    sclr_n = rst_n;
    @(posedge clock);
    sz = model.size();
    if (!rst_n) begin
      model.delete();
      mq = '0;
    end else begin
      if (r && sz > 0) begin
        head = model.pop_front();
        mq   = head;
      end
      if (w && sz < DEPTH) model.push_back(d);
    end
    #1;
    check_outputs(ph);
  endtask

  initial begin
    logic [DW-1:0] pat [4];
    int unsigned bias_w, bias_r;
    pat[0] = 8'h56; pat[1] = 8'hAA; pat[2] = 8'hFF; pat[3] = 8'hAA;
    wrreq = 1'b0; rdreq = 1'b0; data = '0; sclr_n = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 5; i++) step("rst", 1'b0, 1'b0, '0, 1'b0);

    // Four writes then four reads.
    foreach (pat[i]) step("w4", 1'b1, 1'b0, pat[i], 1'b1);
    chk("w4.usedw_const", 32'(usedw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step("r4", 1'b0, 1'b1, '0, 1'b1);
`ifndef FIFO_SHOWAHEAD_EN
      chk("r4.order_const", 32'(q), 32'(pat[i]));
`endif
    end

    // Fill to full, attempt overflow, drain.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b1);
    chk("fill.full_const", 32'(full), 32'd1);
    step("ovf", 1'b1, 1'b0, 8'hEE, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 1'b1, '0, 1'b1);
`ifndef FIFO_SHOWAHEAD_EN
      chk("drain.order_const", 32'(q), 32'(i));
`endif
    end

    // Reads while empty must change nothing.
    for (int i = 0; i < 3; i++) step("rd_empty", 1'b0, 1'b1, '0, 1'b1);

    // Simultaneous write+read at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 1'b0, 8'($urandom), 1'b1);
    for (int i = 0; i < 40; i++) step("wr_rd", 1'b1, 1'b1, 8'($urandom), 1'b1);
    chk("wr_rd.usedw_const", 32'(usedw), 32'd5);

    // Mid-burst reset with a write pending, then a single word round trip.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'($urandom), 1'b1);
    step("rst_wr", 1'b1, 1'b0, 8'h77, 1'b0);
    step("post_wr", 1'b1, 1'b0, 8'h12, 1'b1);
    step("post_rd", 1'b0, 1'b1, '0, 1'b1);
`ifndef FIFO_SHOWAHEAD_EN
    chk("post_rd.q_const", 32'(q), 32'h12);
`endif

    // Random phases with shifting write/read bias to reach both full and empty.
    for (int ph = 0; ph < 8; ph++) begin
      bias_w = (ph % 2 == 0) ? 80 : 30;
      bias_r = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 60; i++)
        step("rand", ($urandom_range(0, 99) < bias_w), ($urandom_range(0, 99) < bias_r),
             8'($urandom), ($urandom_range(0, 99) >= 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
